// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request/response channel plus
// the decode-side outputs and the stall/kill/redirect controls.
// master = fetch queue, slave = environment (memory model + decode stage).
interface inst_fetch_queue_if;
    // instruction memory channel
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    // decode-stage controls
    logic        stall_IF;
    logic        kill_IF;
    logic [31:0] redirect_pc_i;
    // decode-stage instruction
    logic [31:0] inst1_o;
    logic [31:0] pc1_o;
    logic        inst1_valid_o;

    modport master (
        output imem_req_o, imem_addr_o, inst1_o, pc1_o, inst1_valid_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  stall_IF, kill_IF, redirect_pc_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, inst1_o, pc1_o, inst1_valid_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output stall_IF, kill_IF, redirect_pc_i
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Purpose: instruction fetch unit with a DEPTH-entry {inst, pc} queue feeding decode.
// Latency: grant -> inst1_o is 2 cycles minimum (response cycle + registered queue write).
// Backpressure: requests stop once queued + live outstanding reach DEPTH; stall_IF holds the head.
// Ports: clk_i / reset_ni (async active-low); bus (master modport) carries the
// imem req/gnt/rvalid channel, stall/kill/redirect controls and inst1/pc1/valid outputs.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    inst_fetch_queue_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counters get two spare bits: inflight also counts responses that are
    // doomed to be dropped, so it can exceed DEPTH after a kill.
    localparam int            CW      = AW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   tag_mem  [DEPTH];
    logic [AW-1:0] head_q, tail_q, tag_rd_q, tag_wr_q;
    logic [CW-1:0] count_q, inflight_q, drop_q;

    logic          req, accept, resp, drop_resp, enq, deq, kill;
    logic [CW:0]   live;
    logic [CW-1:0] acc_inc, resp_dec;

    assign kill = bus.kill_IF;

    always_comb begin
        // Entries already queued plus live (non-dropped) outstanding requests;
        // each live request owns a reserved slot, so enqueue never overflows.
        live      = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_q};
        req       = reset_ni & ~kill & (live < {1'b0, DEPTH_C});
        accept    = req & bus.imem_gnt_i;
        // A response with nothing outstanding (e.g. left over from before reset) is ignored.
        resp      = bus.imem_rvalid_i & (inflight_q != '0);
        drop_resp = resp & (drop_q != '0);
        enq       = resp & ~drop_resp & ~kill;
        deq       = (count_q != '0) & ~bus.stall_IF & ~kill;
        acc_inc   = {{(CW-1){1'b0}}, accept};
        resp_dec  = {{(CW-1){1'b0}}, resp};
    end

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = pc_q;
    assign bus.inst1_valid_o = (count_q != '0);
    assign bus.inst1_o       = (count_q != '0) ? inst_mem[head_q] : NOP_INST;
    assign bus.pc1_o         = (count_q != '0) ? pc_mem[head_q]   : 32'h0;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pc_q       <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            for (int i = 0; i < DEPTH; i++) tag_mem[i] <= '0;
        end else if (kill) begin
            // Every request still outstanding after this cycle was issued
            // before the kill, so all of them must be discarded on return.
            pc_q       <= bus.redirect_pc_i;
            head_q     <= '0;
            tail_q     <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            count_q    <= '0;
            inflight_q <= inflight_q - resp_dec;
            drop_q     <= inflight_q - resp_dec;
        end else begin
            inflight_q <= inflight_q + acc_inc - resp_dec;
            if (accept) begin
                pc_q              <= pc_q + 32'd4;
                tag_mem[tag_wr_q] <= pc_q;
                tag_wr_q          <= tag_wr_q + AW'(1);
            end
            if (drop_resp) drop_q <= drop_q - CW'(1);
            if (enq) begin
                tail_q   <= tail_q + AW'(1);
                tag_rd_q <= tag_rd_q + AW'(1);
            end
            if (deq) head_q <= head_q + AW'(1);
            count_q <= count_q + {{(CW-1){1'b0}}, enq} - {{(CW-1){1'b0}}, deq};
        end
    end

    // Queue storage needs no reset: it is only observed when count_q > 0.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            inst_mem[tail_q] <= bus.imem_rdata_i;
            pc_mem[tail_q]   <= tag_mem[tag_rd_q];
        end
    end

    assert property (@(posedge clk_i) disable iff (!reset_ni) !(enq && (count_q == DEPTH_C)));
endmodule
